// File: rtl/fetch_stage.sv
// Instruction-fetch stage of the 16-bit pipelined processor.
//
// This stage owns the PC and presents it to the asynchronous instruction memory.
// It captures the returned word into the IF/ID pipeline register.
// A run/halt/fault state machine stops fetching when it sees the exit instruction
// (HALT_INSTR) or the invalid instruction (BAD_INSTR).
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   stall             hold PC, IF/ID, state and fetch_count
//   flush             write a bubble into IF/ID (PC still advances in RUN)
//   redirect          load redirect_pc into PC, bubble IF/ID, return to RUN
//   redirect_pc       redirect target (word address)
//   imem_addr         instruction-memory address (combinationally equal to PC)
//   imem_data         instruction-memory read data
//   ifid_instr        registered instruction for decode
//   ifid_pc           registered PC of ifid_instr
//   ifid_pc_plus1     registered ifid_pc + 1
//   ifid_valid        IF/ID holds a real instruction
//   halted, fault     registered state flags
//   fetch_count       number of valid instructions written into IF/ID (wraps)
module fetch_stage #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [15:0] HALT_INSTR = 16'hFFFF,
  parameter logic [15:0] BAD_INSTR  = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  output logic [15:0] ifid_instr,
  output logic [15:0] ifid_pc,
  output logic [15:0] ifid_pc_plus1,
  output logic        ifid_valid,
  output logic        halted,
  output logic        fault,
  output logic [15:0] fetch_count
);

  typedef enum logic [1:0] {StRun, StHalt, StFault} state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] ipc_q, ipc_d;
  logic [15:0] ipc1_q, ipc1_d;
  logic        valid_q, valid_d;
  logic [15:0] count_q, count_d;
  logic [15:0] pc_plus1;

  assign pc_plus1 = pc_q + 16'd1;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    ipc1_d  = ipc1_q;
    valid_d = valid_q;
    count_d = count_q;

    if (redirect) begin
      // Redirect wins over stall; ifid_pc/ifid_pc_plus1 keep their old values.
      pc_d    = redirect_pc;
      instr_d = '0;
      valid_d = 1'b0;
      state_d = StRun;
    end else if (!stall) begin
      // Every non-stalled cycle defaults to a bubble; only a real fetch overrides it.
      instr_d = '0;
      valid_d = 1'b0;
      if (state_q == StRun) begin
        if (flush) begin
          // Halt/fault detection is suppressed while flushing.
          pc_d = pc_plus1;
        end else if (imem_data == HALT_INSTR) begin
          // The exit instruction retires, but the PC stays on it.
          instr_d = imem_data;
          ipc_d   = pc_q;
          ipc1_d  = pc_plus1;
          valid_d = 1'b1;
          count_d = count_q + 16'd1;
          state_d = StHalt;
        end else if (imem_data == BAD_INSTR) begin
          state_d = StFault;
        end else begin
          instr_d = imem_data;
          ipc_d   = pc_q;
          ipc1_d  = pc_plus1;
          valid_d = 1'b1;
          count_d = count_q + 16'd1;
          pc_d    = pc_plus1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      ipc_q   <= '0;
      ipc1_q  <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      ipc1_q  <= ipc1_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign imem_addr     = pc_q;
  assign ifid_instr    = instr_q;
  assign ifid_pc       = ipc_q;
  assign ifid_pc_plus1 = ipc1_q;
  assign ifid_valid    = valid_q;
  assign halted        = (state_q == StHalt);
  assign fault         = (state_q == StFault);
  assign fetch_count   = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage.
// It runs a directed test-plan walk with literal expectations, then randomized
// stimulus. A behavioural reference model checks every cycle.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush, redirect;
  logic [15:0] redirect_pc;
  logic [15:0] imem_addr, imem_data;
  logic [15:0] ifid_instr, ifid_pc, ifid_pc_plus1, fetch_count;
  logic        ifid_valid, halted, fault;

  // Small memory aliased across the 64K word space by the low address byte.
  logic [15:0] mem [256];
  assign imem_data = mem[imem_addr[7:0]];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .flush        (flush),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .ifid_instr   (ifid_instr),
    .ifid_pc      (ifid_pc),
    .ifid_pc_plus1(ifid_pc_plus1),
    .ifid_valid   (ifid_valid),
    .halted       (halted),
    .fault        (fault),
    .fetch_count  (fetch_count)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model. The mode is "run", "halt" or "fault", and the PC is a plain integer.
  logic        m_ready = 1'b0;
  string       m_mode  = "run";
  int unsigned m_pc, m_cnt;
  logic [15:0] m_instr, m_ipc, m_ipc1;
  logic        m_valid;

  always @(posedge clk) begin
    logic [15:0] word;
    word = mem[m_pc[7:0]];
    if (rst) begin
      m_ready = 1'b1;
      m_mode  = "run";
      m_pc    = 0;
      m_cnt   = 0;
      m_instr = 0; m_ipc = 0; m_ipc1 = 0; m_valid = 0;
    end else if (redirect) begin
      m_pc    = redirect_pc;
      m_instr = 0;
      m_valid = 0;
      m_mode  = "run";
    end else if (stall) begin
      // Everything holds.
    end else if (m_mode != "run") begin
      m_instr = 0;
      m_valid = 0;
    end else if (flush) begin
      m_instr = 0;
      m_valid = 0;
      m_pc    = (m_pc + 1) % 65536;
    end else if (word == 16'hFFFF) begin
      m_instr = word; m_ipc = 16'(m_pc); m_ipc1 = 16'((m_pc + 1) % 65536);
      m_valid = 1;
      m_cnt   = (m_cnt + 1) % 65536;
      m_mode  = "halt";
    end else if (word == 16'h0000) begin
      m_instr = 0;
      m_valid = 0;
      m_mode  = "fault";
    end else begin
      m_instr = word; m_ipc = 16'(m_pc); m_ipc1 = 16'((m_pc + 1) % 65536);
      m_valid = 1;
      m_cnt   = (m_cnt + 1) % 65536;
      m_pc    = (m_pc + 1) % 65536;
    end
  end

  // Compare process: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (m_ready) begin
      check("imem_addr",     imem_addr,           16'(m_pc));
      check("ifid_instr",    ifid_instr,          m_instr);
      check("ifid_pc",       ifid_pc,             m_ipc);
      check("ifid_pc_plus1", ifid_pc_plus1,       m_ipc1);
      check("ifid_valid",    {15'd0, ifid_valid}, {15'd0, m_valid});
      check("halted",        {15'd0, halted},     {15'd0, m_mode == "halt"});
      check("fault",         {15'd0, fault},      {15'd0, m_mode == "fault"});
      check("fetch_count",   fetch_count,         16'(m_cnt));
    end
  end

  // Apply inputs just after an edge, then wait for the next edge (+1).
  task automatic step(input logic r, input logic s, input logic f, input logic rd,
                      input logic [15:0] rpc);
    rst = r; stall = s; flush = f; redirect = rd; redirect_pc = rpc;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect = 1'b0; redirect_pc = 16'h0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
    mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h4444;

    // Reset.
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    check("rst_valid", {15'd0, ifid_valid}, 16'd0);
    check("rst_addr",  imem_addr,           16'h0000);
    check("rst_count", fetch_count,         16'd0);

    // Sequential fetch.
    run(1);
    check("e1_instr", ifid_instr, 16'h1111);
    check("e1_pc",    ifid_pc,    16'h0000);
    run(1);
    check("e2_instr", ifid_instr, 16'h2222);
    check("e2_pc",    ifid_pc,    16'h0001);

    // Two-cycle stall at PC=2.
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
    check("stall_instr", ifid_instr, 16'h2222);
    check("stall_pc",    ifid_pc,    16'h0001);
    check("stall_addr",  imem_addr,  16'h0002);
    run(1);
    check("e3_instr", ifid_instr,  16'h3333);
    check("e3_pc",    ifid_pc,     16'h0002);
    check("e3_count", fetch_count, 16'd3);

    // Redirect overrides stall.
    step(1'b0, 1'b1, 1'b0, 1'b1, 16'h0010);
    check("redir_addr",  imem_addr,           16'h0010);
    check("redir_valid", {15'd0, ifid_valid}, 16'd0);
    run(1);
    check("redir_pc",    ifid_pc,             16'h0010);
    check("redir_instr", ifid_instr,          16'h1010);
    check("redir_valid2", {15'd0, ifid_valid}, 16'd1);

    // Halt on word 3.
    mem[3] = 16'hFFFF;
    step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    run(4);
    check("halt_instr",  ifid_instr,          16'hFFFF);
    check("halt_valid",  {15'd0, ifid_valid}, 16'd1);
    check("halt_flag",   {15'd0, halted},     16'd1);
    check("halt_addr",   imem_addr,           16'h0003);
    run(2);
    check("halt_bubble", {15'd0, ifid_valid}, 16'd0);
    check("halt_count",  fetch_count,         16'd8);

    // Leave halt by redirect, then fault on word 5.
    mem[3] = 16'h3333; mem[5] = 16'h0000;
    step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    check("unhalt", {15'd0, halted}, 16'd0);
    run(6);
    check("fault_flag",  {15'd0, fault},      16'd1);
    check("fault_valid", {15'd0, ifid_valid}, 16'd0);
    check("fault_addr",  imem_addr,           16'h0005);
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    check("rst2_addr",  imem_addr,       16'h0000);
    check("rst2_fault", {15'd0, fault},  16'd0);
    check("rst2_count", fetch_count,     16'd0);

    // PC wrap at FFFF.
    step(1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFF);
    run(1);
    check("wrap_pc",    ifid_pc,       16'hFFFF);
    check("wrap_plus1", ifid_pc_plus1, 16'h0000);
    check("wrap_addr",  imem_addr,     16'h0000);
    check("wrap_instr", ifid_instr,    16'h10FF);

    // Randomized phase.
    for (int i = 0; i < 256; i++) begin
      int unsigned r;
      r = $urandom_range(0, 99);
      if (r < 4)       mem[i] = 16'hFFFF;
      else if (r < 7)  mem[i] = 16'h0000;
      else             mem[i] = 16'($urandom_range(1, 16'hFFFE));
    end
    for (int c = 0; c < 3000; c++) begin
      logic r, s, f, rd;
      logic [15:0] rpc;
      r   = ($urandom_range(0, 199) == 0);
      s   = ($urandom_range(0, 99) < 20);
      f   = ($urandom_range(0, 99) < 15);
      rd  = ($urandom_range(0, 99) < 8);
      rpc = 16'($urandom);
      if ($urandom_range(0, 9) == 0) mem[$urandom_range(0, 255)] = 16'($urandom);
      step(r, s, f, rd, rpc);
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
